// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
//   I2C target (slave) exposing NUM_REGS 8-bit registers behind a 7-bit bus
//   address. A write sets the register pointer (first data byte) and then
//   fills registers with auto-increment. A read returns registers from the
//   current pointer with auto-increment. SCL/SDA are oversampled on clk, so
//   clk must run at least 20x the SCL frequency.
//
//   Ports:
//     clk        system clock
//     reset      asynchronous active-low reset (0 = reset)
//     scl_in     bus SCL level (asynchronous)
//     sda_in     bus SDA level (asynchronous)
//     sda_oe     1 = pull SDA low (open drain), 0 = release
//     reg_q      flattened registers, reg i at [8i+7:8i]
//     wr_strobe  one-cycle pulse when a data byte lands in a register
//     wr_idx     register index written, valid with wr_strobe
//     busy       1 while an addressed transaction is in progress
//
//   Optional build macro I2C_TARGET_GLITCH_FILTER_EN: adds a 3-sample
//   agreement filter per line after the synchronizers (+2 clk latency,
//   pulses of 2 clk or less are ignored).
// ---------------------------------------------------------------------------
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         NUM_REGS    = 4,
    localparam int        PTR_W       = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [8*NUM_REGS-1:0] reg_q,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_idx,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, MACK
    } state_t;

    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic [7:0]       shreg, shreg_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic             sda_oe_n, rw, rw_n, mack, mack_n, busy_n, wr_en;
    logic [7:0]       regs [NUM_REGS];

    // Input path: 2-flop synchronizers; the sync flops reset to the idle bus
    // level (high) so leaving reset never looks like a bus edge.
    logic scl_s1, scl_s2, sda_s1, sda_s2;
    logic scl_f, sda_f, scl_d, sda_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1;
            scl_d  <= 1'b1; sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_in; scl_s2 <= scl_s1;
            sda_s1 <= sda_in; sda_s2 <= sda_s1;
            scl_d  <= scl_f;  sda_d  <= sda_f;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // Two cycles of history plus the current sample; the filtered level only
    // follows once all three agree, otherwise it holds the last accepted
    // level (which is exactly the edge-detect register).
    logic [1:0] scl_h, sda_h;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_h <= 2'b11;
            sda_h <= 2'b11;
        end else begin
            scl_h <= {scl_h[0], scl_s2};
            sda_h <= {sda_h[0], sda_s2};
        end
    end
    assign scl_f = (scl_h == {2{scl_s2}}) ? scl_s2 : scl_d;
    assign sda_f = (sda_h == {2{sda_s2}}) ? sda_s2 : sda_d;
`else
    assign scl_f = scl_s2;
    assign sda_f = sda_s2;
`endif

    logic scl_rise, scl_fall, start_det, stop_det, addr_hit;
    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    // SCL must be high on both samples so an SDA change that coincides with
    // an SCL edge is not mistaken for START/STOP.
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
    // General call (0x00) is never acknowledged.
    assign addr_hit  = (shreg[7:1] == TARGET_ADDR) && (shreg[7:1] != 7'h00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            shreg     <= 8'h00;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            rw        <= 1'b0;
            mack      <= 1'b1;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_idx    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            ptr       <= ptr_n;
            sda_oe    <= sda_oe_n;
            rw        <= rw_n;
            mack      <= mack_n;
            busy      <= busy_n;
            wr_strobe <= wr_en;
            if (wr_en) begin
                regs[ptr] <= shreg;
                wr_idx    <= ptr;
            end
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shreg_n  = shreg;
        ptr_n    = ptr;
        sda_oe_n = sda_oe;
        rw_n     = rw;
        mack_n   = mack;
        busy_n   = busy;
        wr_en    = 1'b0;
        if (start_det) begin
            // busy is kept across a repeated START; it drops if the new
            // address misses.
            state_n  = ADDR;
            cnt_n    = 4'd0;
            sda_oe_n = 1'b0;
        end else if (stop_det) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (scl_rise) begin
            case (state)
                ADDR, PTR, WRITE: begin
                    shreg_n = {shreg[6:0], sda_f};
                    cnt_n   = cnt + 4'd1;
                end
                READ:    cnt_n  = cnt + 4'd1;
                MACK:    mack_n = sda_f;
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state)
                ADDR: if (cnt == 4'd8) begin
                    if (addr_hit) begin
                        state_n  = ADDR_ACK;
                        sda_oe_n = 1'b1;
                        rw_n     = shreg[0];
                        busy_n   = 1'b1;
                    end else begin
                        state_n  = IDLE;
                        sda_oe_n = 1'b0;
                        busy_n   = 1'b0;
                    end
                end
                ADDR_ACK: begin
                    cnt_n = 4'd0;
                    if (rw) begin
                        state_n  = READ;
                        shreg_n  = regs[ptr];
                        sda_oe_n = ~regs[ptr][7];
                    end else begin
                        state_n  = PTR;
                        sda_oe_n = 1'b0;
                    end
                end
                PTR: if (cnt == 4'd8) begin
                    ptr_n    = shreg[PTR_W-1:0];
                    sda_oe_n = 1'b1;
                    state_n  = PTR_ACK;
                end
                PTR_ACK, WRITE_ACK: begin
                    sda_oe_n = 1'b0;
                    cnt_n    = 4'd0;
                    state_n  = WRITE;
                end
                WRITE: if (cnt == 4'd8) begin
                    wr_en    = 1'b1;
                    ptr_n    = ptr + PTR_W'(1);
                    sda_oe_n = 1'b1;
                    state_n  = WRITE_ACK;
                end
                READ: begin
                    if (cnt == 4'd8) begin
                        sda_oe_n = 1'b0;
                        ptr_n    = ptr + PTR_W'(1);
                        state_n  = MACK;
                    end else begin
                        // shreg[7] is on the bus; move to the next bit.
                        sda_oe_n = ~shreg[6];
                        shreg_n  = {shreg[6:0], 1'b0};
                    end
                end
                MACK: begin
                    if (!mack) begin
                        shreg_n  = regs[ptr];
                        sda_oe_n = ~regs[ptr][7];
                        cnt_n    = 4'd0;
                        state_n  = READ;
                    end else begin
                        // Master NACK: stay off the bus until START/STOP.
                        sda_oe_n = 1'b0;
                        busy_n   = 1'b0;
                        state_n  = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_q
        assign reg_q[8*gi +: 8] = regs[gi];
    end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave) endpoint at the opposite end of the bus from the team's I2C master model.
- Exposes a bank of NUM_REGS 8-bit registers over standard 7-bit-address I2C (write with register pointer, read with auto-increment).
- Oversamples SCL/SDA on the system clock; no SCL-domain logic.
- Used as the bus-side responder in bench loopback and as a control/status register block for game logic.

Parameters:
- TARGET_ADDR, 7'h42, 7-bit I2C address the block responds to.
- NUM_REGS, 4, number of 8-bit registers; power of two, 2..16.
- PTR_W, $clog2(NUM_REGS), register pointer width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- scl_in  in  1  bus SCL level (asynchronous).
- sda_in  in  1  bus SDA level (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
- reg_q  out  8*NUM_REGS  flattened register contents; reg i at [8i+7:8i].
- wr_strobe  out  1  one-cycle pulse when a data byte is committed to a register.
- wr_idx  out  PTR_W  index written, valid with wr_strobe.
- busy  out  1  1 from addressed START until STOP or NACK/idle return.

Behaviour:
- Reset (reset=0): sda_oe=0, all registers 0, pointer 0, wr_strobe=0, busy=0, state IDLE.
- Input path: 2-flop synchronizer per line, then edge detect on the synchronized value.
  - scl_rise/scl_fall: synchronized SCL changes.
  - START: synchronized SDA falls while SCL is 1.
  - STOP: synchronized SDA rises while SCL is 1.
- START/STOP take priority over any state.
  - START (including repeated START) -> ADDR, bit counter 0, sda_oe released.
  - STOP -> IDLE, sda_oe=0, busy=0.
- Bits are sampled on scl_rise (MSB first). sda_oe changes only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. At the 8th scl_fall:
    - addr==TARGET_ADDR -> ADDR_ACK, sda_oe=1.
    - otherwise -> IDLE with sda_oe=0; busy drops.
    - busy=1 from START, held only if the address matches.
  - ADDR_ACK: next scl_fall releases SDA.
    - R/W=0 -> PTR, bit counter 0.
    - R/W=1 -> READ: load shift register with reg[ptr]; drive sda_oe=~bit7 on that same fall.
  - PTR: shift 8 bits. At the 8th scl_fall: ptr <= byte[PTR_W-1:0] (upper bits ignored), sda_oe=1 -> PTR_ACK.
  - PTR_ACK: scl_fall releases -> WRITE.
  - WRITE: shift 8 bits. At the 8th scl_fall:
    - reg[ptr] <= byte; wr_strobe=1 for exactly one clk; wr_idx=ptr.
    - ptr <= ptr+1, wrapping mod NUM_REGS.
    - sda_oe=1 -> WRITE_ACK.
  - WRITE_ACK: scl_fall releases -> WRITE (next byte).
  - READ: sda_oe=~current bit, updated on each scl_fall. After the 8th bit's scl_fall: release SDA, ptr <= ptr+1 (wrap) -> MACK.
  - MACK: sample SDA on scl_rise.
    - 0 (ACK): at scl_fall load reg[ptr], drive bit7 -> READ.
    - 1 (NACK): -> IDLE-wait; SDA stays released until STOP/START.
- Pointer persists across transactions; reset is the only thing that clears it.
- A general-call address (0x00) is not acknowledged.
- Reset asserted mid-transfer releases SDA immediately (asynchronous).
- Write in progress when STOP arrives mid-byte: the partial byte is discarded; no wr_strobe.
- Latency: bus event to internal action is 3 clk (2 sync + 1 edge register). Requires clk >= 20x SCL frequency.

Optional Feature:
- Macro I2C_TARGET_GLITCH_FILTER_EN.
- Defined: after the synchronizer, each line passes a 3-sample majority filter; a level change is accepted only when 3 consecutive samples agree. Adds 2 clk latency and suppresses pulses <=2 clk wide.
- Undefined: synchronized values are used directly; 3 clk latency.

Test Plan:
- Reset then idle: reset=0 for 5 clk, release -> sda_oe=0, reg_q=0, busy=0; no ACK on bus idle for 1000 clk.
- Write: START, 0x84 (0x42,W), ptr 0x01, data 0xA5, 0x3C, STOP -> ACK on all 4 bytes. reg1=0xA5, reg2=0x3C. Two wr_strobe pulses with wr_idx 1 then 2.
- Pointer wrap: write ptr 0x03, data 0x11, 0x22 -> reg3=0x11, reg0=0x22, pointer ends at 1.
- Read with repeated START: START 0x84, ptr 0x02, rSTART 0x85, read 2 bytes (master ACK then NACK), STOP -> SDA returns 0x3C then 0x11 (prior values); sda_oe=0 after NACK.
- Wrong address: START 0x86, 3 bytes, STOP -> sda_oe never 1, busy stays 0, registers unchanged.
- Mid-byte abort: after 4 data bits, STOP -> no wr_strobe, register unchanged. Repeat with reset=0 at the same point -> sda_oe=0 within the same cycle. With I2C_TARGET_GLITCH_FILTER_EN defined, a 2-clk SCL low glitch mid-byte does not shift a bit.
